delay_scheduler: RTL and testbench

Shares one delay counter between NUM_REQ requesters, e.g. the ball-update, paddle-update and score-flash paths of the VGA pong driver.
Each requester holds a level request. The block grants the counter round-robin, loads that requester's delay length, counts it out and returns a one-cycle done pulse to the winner.
It is the sequencing/arbitration layer above per-path delay state machines. Requesters use it instead of owning private timers.

---
 rtl/pong_pkg.sv | 14 +
 rtl/delay_scheduler_rr_pick.sv | 31 +++
 rtl/delay_scheduler.sv | 119 +++++++++++
 tb/tb_delay_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong delay scheduling layer: FSM state
// encoding and default sizing of the shared delay counter.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF = 3;
  localparam int CNT_W_DEF   = 24;

endpackage

// File: rtl/delay_scheduler_rr_pick.sv
// Round-robin picker: returns the first set request bit found when
// searching from ptr upwards, wrapping modulo NUM_REQ.
module rr_pick
  import pong_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  logic [IDX_W-1:0] pos;

  // Scan ptr, ptr+1, ... and latch onto the first requester found
  always_comb begin
    idx = '0;
    vld = 1'b0;
    pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!vld && req[pos]) begin
        vld = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Shares one down-counter between NUM_REQ requesters. A round-robin
// winner is granted the counter, its delay length is loaded at grant
// time, and a one-cycle done pulse is returned when the count expires.
// Dropping the request mid-count aborts silently.
module delay_scheduler
  import pong_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     CLK_100MHz,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] delay_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, len_sel;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt, owner_inc;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Select the delay length belonging to the current round-robin winner
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        len_sel = delay_len[i*CNT_W +: CNT_W];
      end
    end
  end

  // Pointer value that starts the next search just past the current owner
  always_comb begin
    owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    done_nxt  = '0;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt = S_COUNT;
          grant_nxt = NUM_REQ'(1) << pick_idx;
          cnt_nxt   = len_sel;
          owner_nxt = pick_idx;
        end
      end
      S_COUNT: begin
        // A dropped request wins over expiry on the same edge
        if (!req[owner]) begin
          state_nxt = S_IDLE;
          grant_nxt = '0;
          ptr_nxt   = owner_inc;
        end else if (cnt == '0) begin
          state_nxt = S_DONE;
          done_nxt  = grant;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DONE: begin
        // Request level is ignored here; done has already been issued
        state_nxt = S_IDLE;
        grant_nxt = '0;
        ptr_nxt   = owner_inc;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      state <= S_IDLE;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      done  <= done_nxt;
      busy  <= (state_nxt != S_IDLE);
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler (NUM_REQ=3, L0=4, L1=2, L2=0) and rr_pick.
module tb_delay_scheduler;

  localparam int NR = 3;
  localparam int CW = 24;

  logic             CLK_100MHz;
  logic             Reset;
  logic [NR-1:0]    req;
  logic [NR*CW-1:0] delay_len;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic             busy;

  logic [NR-1:0]    rr_req;
  logic [1:0]       rr_ptr;
  logic [1:0]       rr_idx;
  logic             rr_vld;

  delay_scheduler #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .CLK_100MHz (CLK_100MHz),
    .Reset      (Reset),
    .req        (req),
    .delay_len  (delay_len),
    .grant      (grant),
    .done       (done),
    .busy       (busy)
  );

  rr_pick #(.NUM_REQ(NR), .IDX_W(2)) u_pick (
    .req (rr_req),
    .ptr (rr_ptr),
    .idx (rr_idx),
    .vld (rr_vld)
  );

  initial CLK_100MHz = 1'b0;
  always #5 CLK_100MHz = ~CLK_100MHz;

  int edge_n = 0;
  always @(posedge CLK_100MHz) edge_n <= edge_n + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard of expected done pulses: requester and edge after which it is high
  typedef struct {
    int bitn;
    int cyc;
  } exp_t;
  exp_t sbq[$];

  int len_tab[NR] = '{4, 2, 0};

  // Picker vectors
  typedef struct {
    logic [2:0] req;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       vld;
  } rr_vec_t;
  rr_vec_t rr_tab[$];

  // Scheduler rows: inputs driven before an edge, grant expected after it;
  // sched >= 0 marks an edge that grants that requester a full count
  typedef struct {
    logic [2:0] req;
    logic       rst;
    logic [2:0] grant;
    int         sched;
  } row_t;
  row_t rows[$];

  task automatic add(input logic [2:0] r, input logic rs, input logic [2:0] g, input int s);
    row_t x;
    x.req = r; x.rst = rs; x.grant = g; x.sched = s;
    rows.push_back(x);
  endtask

  task automatic add_n(input int n, input logic [2:0] r, input logic rs, input logic [2:0] g);
    for (int j = 0; j < n; j++) add(r, rs, g, -1);
  endtask

  task automatic add_rr(input logic [2:0] r, input logic [1:0] p, input logic [1:0] i, input logic v);
    rr_vec_t x;
    x.req = r; x.ptr = p; x.idx = i; x.vld = v;
    rr_tab.push_back(x);
  endtask

  // Done monitor: every cycle, done must equal the scoreboard head if due, else zero
  initial begin
    logic [NR-1:0] exp_done;
    forever begin
      @(posedge CLK_100MHz);
      #1;
      exp_done = '0;
      if (sbq.size() > 0 && sbq[0].cyc == edge_n) begin
        exp_done = NR'(1) << sbq[0].bitn;
        sbq.delete(0);
      end
      check("done", 32'(done), 32'(exp_done));
    end
  end

  initial begin
    Reset     = 1'b1;
    req       = 3'b111;
    delay_len = {24'd0, 24'd2, 24'd4};
    rr_req    = '0;
    rr_ptr    = '0;

    add_rr(3'b000, 2'd0, 2'd0, 1'b0);
    add_rr(3'b001, 2'd0, 2'd0, 1'b1);
    add_rr(3'b001, 2'd1, 2'd0, 1'b1);
    add_rr(3'b001, 2'd2, 2'd0, 1'b1);
    add_rr(3'b110, 2'd0, 2'd1, 1'b1);
    add_rr(3'b110, 2'd2, 2'd2, 1'b1);
    add_rr(3'b101, 2'd1, 2'd2, 1'b1);
    add_rr(3'b101, 2'd2, 2'd2, 1'b1);
    add_rr(3'b111, 2'd1, 2'd1, 1'b1);
    add_rr(3'b111, 2'd2, 2'd2, 1'b1);
    add_rr(3'b011, 2'd2, 2'd0, 1'b1);
    add_rr(3'b010, 2'd0, 2'd1, 1'b1);

    // Reset held two cycles with all requests up
    add_n(2, 3'b111, 1'b1, 3'b000);
    // All requesting: 0, 1, 2 then 0 again; the last one is aborted
    add(3'b111, 1'b0, 3'b001, 0);
    add_n(5, 3'b111, 1'b0, 3'b001);
    add(3'b111, 1'b0, 3'b000, -1);
    add(3'b111, 1'b0, 3'b010, 1);
    add_n(3, 3'b111, 1'b0, 3'b010);
    add(3'b111, 1'b0, 3'b000, -1);
    add(3'b111, 1'b0, 3'b100, 2);
    add(3'b111, 1'b0, 3'b100, -1);
    add(3'b111, 1'b0, 3'b000, -1);
    add(3'b111, 1'b0, 3'b001, -1);
    add(3'b000, 1'b0, 3'b000, -1);
    // Single requester 0; request dropped during the done cycle
    add(3'b001, 1'b0, 3'b001, 0);
    add_n(5, 3'b001, 1'b0, 3'b001);
    add_n(2, 3'b000, 1'b0, 3'b000);
    // Single requester 2 with zero length
    add(3'b100, 1'b0, 3'b100, 2);
    add(3'b100, 1'b0, 3'b100, -1);
    add(3'b000, 1'b0, 3'b000, -1);
    // 0 then 1; 1 aborts, then 2 is served before 0
    add(3'b011, 1'b0, 3'b001, 0);
    add_n(5, 3'b011, 1'b0, 3'b001);
    add(3'b011, 1'b0, 3'b000, -1);
    add(3'b011, 1'b0, 3'b010, -1);
    add(3'b011, 1'b0, 3'b010, -1);
    add(3'b000, 1'b0, 3'b000, -1);
    add(3'b101, 1'b0, 3'b100, 2);
    add(3'b101, 1'b0, 3'b100, -1);
    add(3'b101, 1'b0, 3'b000, -1);
    // Reset pulse mid-count of requester 0, then a full re-count
    add(3'b101, 1'b0, 3'b001, -1);
    add(3'b101, 1'b0, 3'b001, -1);
    add(3'b101, 1'b1, 3'b000, -1);
    add(3'b101, 1'b0, 3'b001, 0);
    add_n(5, 3'b101, 1'b0, 3'b001);
    add_n(2, 3'b000, 1'b0, 3'b000);

    for (int i = 0; i < rr_tab.size(); i++) begin
      rr_req = rr_tab[i].req;
      rr_ptr = rr_tab[i].ptr;
      #1;
      check($sformatf("rr_vld vec %0d", i), 32'(rr_vld), 32'(rr_tab[i].vld));
      if (rr_tab[i].vld) begin
        check($sformatf("rr_idx vec %0d", i), 32'(rr_idx), 32'(rr_tab[i].idx));
      end
    end

    @(posedge CLK_100MHz);
    #1;

    for (int i = 0; i < rows.size(); i++) begin
      req   = rows[i].req;
      Reset = rows[i].rst;
      if (rows[i].sched >= 0) begin
        exp_t e;
        e.bitn = rows[i].sched;
        e.cyc  = edge_n + 1 + len_tab[rows[i].sched] + 1;
        sbq.push_back(e);
      end
      @(posedge CLK_100MHz);
      #1;
      check($sformatf("grant row %0d", i), 32'(grant), 32'(rows[i].grant));
      check($sformatf("busy row %0d", i), 32'(busy), 32'(rows[i].grant != 3'b000));
    end

    repeat (2) begin
      @(posedge CLK_100MHz);
      #1;
    end
    check("pending done pulses", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
